// File: rtl/mem_burst_pkg.sv
// Shared constants and state type for mem_burst_reader and its skid FIFO.
// Optional feature macro: BURST_CHECKSUM_EN (used by mem_burst_reader).
package mem_burst_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned BUF_PTR_W = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } burst_state_e;

  // Plain-vector state codes kept for the legacy FSM register.
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

endpackage

// File: rtl/burst_skid_fifo.sv
// Small synchronous FIFO holding {last, data} words between the memory read
// pipeline and the output stream; the head entry drives the stream directly.
module burst_skid_fifo
  import mem_burst_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_last,
  input  logic                 i_pop,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_last,
  output logic [BUF_CNT_W-1:0] o_count,
  output logic                 o_empty,
  output logic                 o_full
);

  logic [DATA_W:0]          r_mem [BUF_DEPTH];
  logic [BUF_PTR_W-1:0]     r_wr_ptr;
  logic [BUF_PTR_W-1:0]     r_rd_ptr;
  logic [BUF_CNT_W-1:0]     r_count;
  logic                     w_do_pop;

  assign w_do_pop = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= {i_last, i_data};
        r_wr_ptr        <= r_wr_ptr + BUF_PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + BUF_PTR_W'(1);
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + BUF_CNT_W'(1);
        2'b01:   r_count <= r_count - BUF_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign {o_last, o_data} = r_mem[r_rd_ptr];
  assign o_count          = r_count;
  assign o_empty          = (r_count == '0);
  assign o_full           = (r_count == BUF_CNT_W'(BUF_DEPTH));

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read sequencer: walks a wrapping address range on a 1-cycle-latency
// memory and streams words out with valid/ready/last. Optional: BURST_CHECKSUM_EN.
module mem_burst_reader
  import mem_burst_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef BURST_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [BUF_CNT_W:0] CREDIT_MAX = (BUF_CNT_W + 1)'(BUF_DEPTH);

  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_issued;
  logic [ADDR_W-1:0]   r_mem_raddr;
  logic                r_busy;
  logic                r_done;
  // v0/l0: address register stage; v1/l1: memory data stage.
  logic                r_v0;
  logic                r_l0;
  logic                r_v1;
  logic                r_l1;

  logic [DATA_W-1:0]    w_head_data;
  logic                 w_head_last;
  logic [BUF_CNT_W-1:0] w_fifo_count;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [BUF_CNT_W:0]   w_outstanding;
  logic                 w_issue;
  logic                 w_last_issue;
  logic                 w_pop;
  logic                 w_fin;

  // Credit counts buffered words plus reads still in the pipeline, so the
  // buffer can never be asked to take a word it has no room for.
  assign w_outstanding = {1'b0, w_fifo_count}
                       + (BUF_CNT_W + 1)'(r_v0)
                       + (BUF_CNT_W + 1)'(r_v1);
  assign w_issue       = (r_state == ST_RUN) && (r_issued < r_len)
                       && (w_outstanding < CREDIT_MAX);
  assign w_last_issue  = w_issue && (r_issued == (r_len - (ADDR_W + 1)'(1)));
  assign w_pop         = !w_fifo_empty && out_ready;
  assign w_fin         = (r_state == ST_DRAIN) && w_pop && w_head_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_mem_raddr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_v0        <= 1'b0;
      r_l0        <= 1'b0;
      r_v1        <= 1'b0;
      r_l1        <= 1'b0;
    end else begin
      assert (!(r_v1 && w_fifo_full));
      r_done <= 1'b0;
      r_v0   <= w_issue;
      r_l0   <= w_last_issue;
      r_v1   <= r_v0;
      r_l1   <= r_l0;
      if (w_issue) begin
        r_mem_raddr <= r_base + r_issued[ADDR_W-1:0];
        r_issued    <= r_issued + (ADDR_W + 1)'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_base   <= base_addr;
              r_len    <= len;
              r_issued <= '0;
              r_busy   <= 1'b1;
              r_state  <= ST_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_last_issue) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_fin) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  burst_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_v1),
    .i_data  (mem_rdata),
    .i_last  (r_l1),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_last  (w_head_last),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_raddr = r_mem_raddr;
  assign out_valid = !w_fifo_empty;
  assign out_data  = w_head_data;
  assign out_last  = w_head_last && !w_fifo_empty;

`ifdef BURST_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset)                          r_checksum <= '0;
    else if (r_state == ST_IDLE && start) r_checksum <= '0;
    else if (w_pop)                     r_checksum <= r_checksum ^ w_head_data;
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: vector table of bursts plus random
// bursts, each scored against an address/data queue model; reset-abort sequence.
module tb_mem_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  len;
  logic        busy;
  logic        done;
  logic [4:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
`ifdef BURST_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  mem_burst_reader #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef BURST_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  typedef struct {
    int base;
    int blen;
    int rmode;      // 0: always ready, 1: 1,0,0 repeating, 2: random
    bit junk;       // drive ignored start commands while busy
    int exp_first;  // cycle of first out_valid, -1 = no check
    int exp_done;   // cycle of done pulse, -1 = no check
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return (idx % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Cycle n = negedge following the n-th posedge after the start-sampling edge.
  task automatic run_burst(input vec_t v);
    logic [31:0] q[$];
    logic [31:0] xs;
    logic [31:0] prev_d;
    logic        prev_l;
    logic        prev_stall;
    logic        r;
    int          first_v;
    int          done_at;
    int          ndone;
    xs = '0;
    prev_d = '0;
    prev_l = 1'b0;
    for (int k = 0; k < v.blen; k++) q.push_back(32'h100 + 32'((v.base + k) % 32));
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 5'(v.base);
    len        = 6'(v.blen);
    out_ready  = ready_for(v.rmode, 0);
    prev_stall = 1'b0;
    first_v    = -1;
    done_at    = -1;
    ndone      = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'(1'b1));
        chk("hold_data", 64'(out_data), 64'(prev_d));
        chk("hold_last", 64'(out_last), 64'(prev_l));
      end
      if (out_valid && first_v < 0) first_v = n;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
        chk("done_words_left", 64'(q.size()), 64'(0));
        chk("busy_at_done", 64'(busy), 64'(0));
`ifdef BURST_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(xs));
`endif
      end else if (done_at < 0) begin
        chk("busy", 64'(busy), 64'(v.blen != 0));
      end else begin
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("valid_after_done", 64'(out_valid), 64'(0));
      end
      r = ready_for(v.rmode, n + 1);
      out_ready  = r;
      prev_stall = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("extra_word", 64'(out_valid), 64'(0));
        end else if (r) begin
          chk("data", 64'(out_data), 64'(q[0]));
          chk("last", 64'(out_last), 64'(q.size() == 1));
          xs = xs ^ q.pop_front();
        end else begin
          prev_stall = 1'b1;
          prev_d     = q[0];
          prev_l     = (q.size() == 1);
        end
      end
      if (v.junk && done_at < 0) begin
        start     = 1'($urandom_range(0, 1));
        base_addr = 5'($urandom);
        len       = 6'($urandom_range(0, 32));
      end else begin
        start = 1'b0;
      end
      if (done_at >= 0 && n >= done_at + 2) break;
    end
    start = 1'b0;
    chk("done_seen", 64'(done_at >= 0), 64'(1));
    chk("done_pulses", 64'(ndone), 64'(1));
    chk("words_left", 64'(q.size()), 64'(0));
    if (v.blen == 0) chk("no_valid_len0", 64'(first_v), 64'(-1));
    else if (v.exp_first >= 0) chk("first_latency", 64'(first_v), 64'(v.exp_first));
    if (v.exp_done >= 0) chk("done_cycle", 64'(done_at), 64'(v.exp_done));
  endtask

  initial begin
    vec_t rv;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    out_ready = 1'b0;
    tbl[0] = '{3,  5,  0, 1'b0, 3, 8};
    tbl[1] = '{30, 4,  0, 1'b0, 3, 7};
    tbl[2] = '{0,  32, 1, 1'b0, 3, -1};
    tbl[3] = '{0,  0,  0, 1'b0, -1, 0};
    tbl[4] = '{31, 1,  0, 1'b0, 3, 4};
    tbl[5] = '{0,  32, 0, 1'b0, 3, 35};
    tbl[6] = '{7,  9,  2, 1'b1, 3, -1};
    tbl[7] = '{20, 17, 1, 1'b1, 3, -1};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_raddr", 64'(mem_raddr), 64'(0));
`ifdef BURST_CHECKSUM_EN
    chk("rst_checksum", 64'(checksum), 64'(0));
`endif
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_burst(tbl[i]);

`ifdef BURST_CHECKSUM_EN
    rv = '{0, 3, 0, 1'b0, 3, 6};
    run_burst(rv);
    chk("checksum_hold", 64'(checksum), 64'(32'h103));
`endif

    // Reset during word 2 of a len-8 burst aborts it without a done pulse.
    @(negedge clk);
    start     = 1'b1;
    base_addr = 5'd0;
    len       = 6'd8;
    out_ready = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_pre_valid", 64'(out_valid), 64'(1));
    chk("abort_pre_data", 64'(out_data), 64'(32'h102));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("abort_quiet_done", 64'(done), 64'(0));
      chk("abort_quiet_valid", 64'(out_valid), 64'(0));
    end
    rv = '{5, 2, 0, 1'b0, 3, 5};
    run_burst(rv);

    for (int i = 0; i < 15; i++) begin
      rv = '{int'($urandom_range(0, 31)), int'($urandom_range(0, 32)), 2, 1'b1, 3, -1};
      run_burst(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
